// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared game types: scroller state encoding, level/world
//               index widths and the world-dependent scroll speed.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    localparam int c_level_w = 3;
    localparam int c_world_w = 3;

    typedef enum logic [1:0] {
        ARMED     = 2'd0,
        SCROLL    = 2'd1,
        COMPLETE  = 2'd2,
        WAIT_NEXT = 2'd3
    } scroll_state_t;

    // Pixels per scroll step: world 0 moves 1 px, world 7 moves 8 px.
    // One extra bit so world 7 does not wrap.
    function automatic logic [c_world_w:0] world_step(input logic [c_world_w-1:0] world);
        return {1'b0, world} + {{c_world_w{1'b0}}, 1'b1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Free-running divider that flags the cycle in which a scroll
//               step is due. Holds while run is low, clears on clear.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int TICK_DIV = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int c_cnt_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_terminal = c_cnt_w'(TICK_DIV - 1);

    logic [c_cnt_w-1:0] r_count;

    // Clear wins over a coincident terminal count, so a rewind never steps.
    assign tick = run && !clear && (r_count == c_terminal);

    // Count 0..TICK_DIV-1 while running; pausing keeps the partial count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (run) begin
            if (r_count == c_terminal) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/level_scroller.sv
`default_nettype none
// ============================================================================
// Module      : level_scroller
// Description : Horizontal scroll progress through a level. Speed scales with
//               the world, pauses on player_disable, rewinds on player_dead
//               and emits one level_complete pulse per traversal.
// Revision    : 1.0 - initial release
// ============================================================================
module level_scroller
    import game_pkg::*;
#(
    parameter int TICK_DIV  = 1000000,
    parameter int LEVEL_LEN = 640,
    parameter int POS_W     = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [c_level_w-1:0] level,
    input  logic [c_world_w-1:0] world,
    input  logic                 player_disable,
    input  logic                 player_dead,
    output logic [POS_W-1:0]     scroll_x,
    output logic                 step_tick,
    output logic                 level_complete,
    output logic                 scrolling
);

    localparam logic [POS_W-1:0] c_len = POS_W'(LEVEL_LEN);

    scroll_state_t        r_state;
    scroll_state_t        w_state_next;
    logic [c_level_w-1:0] r_level_q;
    logic [c_world_w-1:0] r_world_q;
    logic                 w_chg;
    logic                 w_run;
    logic                 w_clear;
    logic                 w_tick;
    logic [POS_W-1:0]     w_step;
    logic [POS_W-1:0]     w_sum;
    logic [POS_W-1:0]     w_stepped;
    logic [POS_W-1:0]     w_scroll_next;
    logic                 w_step_tick_next;

    // Any level or world change restarts the traversal from scratch.
    assign w_chg   = (level != r_level_q) || (world != r_world_q);
    assign w_run   = (r_state == SCROLL) && !player_disable;
    assign w_clear = w_chg || player_dead || (r_state != SCROLL);

    // LEVEL_LEN + 8 fits in POS_W, so the sum cannot wrap before saturation.
    assign w_step    = POS_W'(world_step(world));
    assign w_sum     = scroll_x + w_step;
    assign w_stepped = (w_sum >= c_len) ? c_len : w_sum;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .run   (w_run),
        .clear (w_clear),
        .tick  (w_tick)
    );

    // Previous level/world for change detection; reset captures the live value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level_q <= level;
            r_world_q <= world;
        end else begin
            r_level_q <= level;
            r_world_q <= world;
        end
    end

    // Next state and next output values; change detect overrides every state.
    always_comb begin
        w_state_next     = r_state;
        w_scroll_next    = scroll_x;
        w_step_tick_next = 1'b0;
        if (w_chg) begin
            w_state_next  = ARMED;
            w_scroll_next = '0;
        end else begin
            case (r_state)
                ARMED: begin
                    w_scroll_next = '0;
                    if (!player_disable) begin
                        w_state_next = SCROLL;
                    end
                end
                SCROLL: begin
                    if (player_dead) begin
                        w_scroll_next = '0;
                    end else if (scroll_x == c_len) begin
                        w_state_next = COMPLETE;
                    end else if (w_tick) begin
                        w_scroll_next    = w_stepped;
                        w_step_tick_next = 1'b1;
                    end
                end
                COMPLETE: begin
                    w_scroll_next = c_len;
                    w_state_next  = WAIT_NEXT;
                end
                WAIT_NEXT: begin
                    w_scroll_next = c_len;
                end
                default: begin
                    w_state_next  = ARMED;
                    w_scroll_next = '0;
                end
            endcase
        end
    end

    // State register with registered outputs derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ARMED;
            scroll_x       <= '0;
            step_tick      <= 1'b0;
            level_complete <= 1'b0;
            scrolling      <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            scroll_x       <= w_scroll_next;
            step_tick      <= w_step_tick_next;
            level_complete <= (w_state_next == COMPLETE);
            scrolling      <= (w_state_next == SCROLL);
        end
    end

endmodule
`default_nettype wire
